// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, LSB-first data, optional
// even/odd parity and one or two stop bits, each bit held for Prescale clocks.
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP_SEL,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      S_DATA,
    output logic                      busy
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]                state;
    logic [PRESCALE_WIDTH-1:0] n_lat;
    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0]     data_lat;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          next_idx;
    logic                      par_en_lat;
    logic                      par_bit;
    logic                      stop_sel_lat;
    logic                      stop_second;
    logic                      bit_end;

    assign bit_end  = (cnt == n_lat - PS_ONE);
    assign next_idx = idx + IDX_ONE;

    // S_DATA is loaded with the value of the bit being entered, so the line
    // only ever changes on the same edge that starts a new bit period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            S_DATA       <= 1'b1;
            busy         <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            n_lat        <= '0;
            data_lat     <= '0;
            par_en_lat   <= 1'b0;
            par_bit      <= 1'b0;
            stop_sel_lat <= 1'b0;
            stop_second  <= 1'b0;
        end else begin
            if (state != IDLE) begin
                cnt <= bit_end ? '0 : cnt + PS_ONE;
            end
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        data_lat     <= P_DATA;
                        par_en_lat   <= PAR_EN;
                        par_bit      <= (^P_DATA) ^ PAR_TYP;
                        stop_sel_lat <= STOP_SEL;
                        n_lat        <= (Prescale == '0) ? PS_ONE : Prescale;
                        stop_second  <= 1'b0;
                        cnt          <= '0;
                        state        <= START;
                        S_DATA       <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        idx    <= '0;
                        S_DATA <= data_lat[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == LAST_IDX) begin
                            if (par_en_lat) begin
                                state  <= PARITY;
                                S_DATA <= par_bit;
                            end else begin
                                state       <= STOP;
                                S_DATA      <= 1'b1;
                                stop_second <= 1'b0;
                            end
                        end else begin
                            idx    <= next_idx;
                            S_DATA <= data_lat[next_idx];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state       <= STOP;
                        S_DATA      <= 1'b1;
                        stop_second <= 1'b0;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_sel_lat && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    S_DATA <= 1'b1;
                    busy   <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: 8-bit and 5-bit instances, expected line
// bits and frame lengths queued at issue time and checked by line monitors.
module tb_uart_tx_cfg;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] p_data8 = '0;
    logic [4:0] p_data5 = '0;
    logic       dv8 = 1'b0;
    logic       dv5 = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop_sel = 1'b0;
    logic [5:0] prescale = '0;
    logic       s_data8, busy8, s_data5, busy5;

    int checks = 0;
    int errors = 0;

    bit q8[$];
    bit q5[$];
    int len8_q[$];
    int len5_q[$];
    int busy_run8 = 0, idle_run8 = 0, last_gap8 = -1;
    int busy_run5 = 0, idle_run5 = 0;

    always #5 CLK = ~CLK;

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data8), .Data_Valid(dv8),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP_SEL(stop_sel),
        .Prescale(prescale), .S_DATA(s_data8), .busy(busy8)
    );

    uart_tx_cfg #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data5), .Data_Valid(dv5),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP_SEL(stop_sel),
        .Prescale(prescale), .S_DATA(s_data5), .busy(busy5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the 8-bit instance: one line sample per busy cycle.
    always @(negedge CLK) begin
        if (RST) begin
            busy_run8 = 0;
            idle_run8 = 0;
            q8.delete();
            len8_q.delete();
        end else if (busy8) begin
            if (busy_run8 == 0) last_gap8 = idle_run8;
            idle_run8 = 0;
            busy_run8++;
            if (q8.size() == 0) check("dut8_unexpected_busy", 32'(busy8), 32'd0);
            else check("dut8_sdata", 32'(s_data8), 32'(q8.pop_front()));
        end else begin
            if (busy_run8 != 0) begin
                if (len8_q.size() == 0) check("dut8_frame_len", 32'(busy_run8), 32'd0);
                else check("dut8_frame_len", 32'(busy_run8), 32'(len8_q.pop_front()));
                busy_run8 = 0;
            end
            idle_run8++;
            check("dut8_idle_high", 32'(s_data8), 32'd1);
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            busy_run5 = 0;
            idle_run5 = 0;
            q5.delete();
            len5_q.delete();
        end else if (busy5) begin
            idle_run5 = 0;
            busy_run5++;
            if (q5.size() == 0) check("dut5_unexpected_busy", 32'(busy5), 32'd0);
            else check("dut5_sdata", 32'(s_data5), 32'(q5.pop_front()));
        end else begin
            if (busy_run5 != 0) begin
                if (len5_q.size() == 0) check("dut5_frame_len", 32'(busy_run5), 32'd0);
                else check("dut5_frame_len", 32'(busy_run5), 32'(len5_q.pop_front()));
                busy_run5 = 0;
            end
            idle_run5++;
            check("dut5_idle_high", 32'(s_data5), 32'd1);
        end
    end

    // pat lists the line bits left to right as written (first sent = MSB of nb bits).
    task automatic expect8(input logic [15:0] pat, input int nb, input int n);
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < n; j++) q8.push_back(pat[nb-1-i]);
        len8_q.push_back(nb * n);
    endtask

    task automatic expect5(input logic [15:0] pat, input int nb, input int n);
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < n; j++) q5.push_back(pat[nb-1-i]);
        len5_q.push_back(nb * n);
    endtask

    task automatic send8(input logic [7:0] d, input logic pe, input logic pt, input logic ss,
                         input logic [5:0] ps, input logic [15:0] pat, input int nb);
        expect8(pat, nb, (ps == 6'd0) ? 1 : int'(ps));
        p_data8 = d; par_en = pe; par_typ = pt; stop_sel = ss; prescale = ps; dv8 = 1'b1;
        @(posedge CLK); #1;
        dv8 = 1'b0;
        p_data8 = ~d; par_en = ~pe; par_typ = ~pt; stop_sel = ~ss; prescale = ps + 6'd3;
    endtask

    task automatic send5(input logic [4:0] d, input logic pe, input logic pt, input logic ss,
                         input logic [5:0] ps, input logic [15:0] pat, input int nb);
        expect5(pat, nb, (ps == 6'd0) ? 1 : int'(ps));
        p_data5 = d; par_en = pe; par_typ = pt; stop_sel = ss; prescale = ps; dv5 = 1'b1;
        @(posedge CLK); #1;
        dv5 = 1'b0;
        p_data5 = ~d; par_en = ~pe; par_typ = ~pt; stop_sel = ~ss; prescale = ps + 6'd5;
    endtask

    task automatic wait_idle8();
        int t = 0;
        while (busy8 && t < 1000) begin @(posedge CLK); #1; t++; end
        if (busy8) check("dut8_idle_timeout", 32'(busy8), 32'd0);
    endtask

    task automatic wait_idle5();
        int t = 0;
        while (busy5 && t < 1000) begin @(posedge CLK); #1; t++; end
        if (busy5) check("dut5_idle_timeout", 32'(busy5), 32'd0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_sdata8", 32'(s_data8), 32'd1);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_sdata5", 32'(s_data5), 32'd1);
        check("rst_busy5", 32'(busy5), 32'd0);
        RST = 1'b0;
        repeat (20) @(posedge CLK);
        #1;

        // A5, even parity, one stop, one clock per bit
        send8(8'hA5, 1'b1, 1'b0, 1'b0, 6'd1, 16'b01010010101, 11);
        wait_idle8();
        repeat (2) @(posedge CLK);
        #1;

        // 01, odd parity, two stops, four clocks per bit
        send8(8'h01, 1'b1, 1'b1, 1'b1, 6'd4, 16'b010000000011, 12);
        wait_idle8();
        repeat (2) @(posedge CLK);
        #1;

        // 5-bit word, no parity, Prescale 0 acts as 1
        send5(5'h13, 1'b0, 1'b0, 1'b0, 6'd0, 16'b0110011, 7);
        wait_idle5();
        repeat (2) @(posedge CLK);
        #1;

        // Back-to-back with Data_Valid held; data change mid-frame must not leak
        expect8(16'b0001111001, 10, 2);
        expect8(16'b0111111111, 10, 2);
        p_data8 = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop_sel = 1'b0; prescale = 6'd2;
        dv8 = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        p_data8 = 8'hFF;
        wait_idle8();
        t = 0;
        while (!busy8 && t < 20) begin @(posedge CLK); #1; t++; end
        check("b2b_second_start", 32'(busy8), 32'd1);
        dv8 = 1'b0;
        @(posedge CLK);
        #1;
        check("b2b_idle_gap", 32'(last_gap8), 32'd1);
        wait_idle8();
        repeat (2) @(posedge CLK);
        #1;

        // Reset during data bit 3 of 55, then a clean frame right after release
        send8(8'h55, 1'b1, 1'b0, 1'b0, 6'd1, 16'b01010101001, 11);
        repeat (4) @(posedge CLK);
        #1;
        check("midrst_bit3", 32'(s_data8), 32'd0);
        RST = 1'b1;
        #1;
        check("midrst_sdata", 32'(s_data8), 32'd1);
        check("midrst_busy", 32'(busy8), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        send8(8'h55, 1'b1, 1'b0, 1'b0, 6'd1, 16'b01010101001, 11);
        wait_idle8();

        repeat (3) @(negedge CLK);
        #1;
        check("dut8_bits_drained", 32'(q8.size()), 32'd0);
        check("dut8_frames_drained", 32'(len8_q.size()), 32'd0);
        check("dut5_bits_drained", 32'(q5.size()), 32'd0);
        check("dut5_frames_drained", 32'(len5_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
